fir_mavg_param: RTL and testbench
=================================

FIR_MAVG_PARAM -- requirements
Module: fir_mavg_param

Interface
REQ-001 Parameter DATA_W, default 16, signed input sample width.
REQ-002 Parameter LOG2_N, default 3, log2 of window length N = 2^LOG2_N; legal range 1..5.
REQ-003 Parameter AVG, default 0, output mode: 0 = window sum, 1 = rounded window average.
REQ-004 Derived localparam OUT_W = DATA_W + LOG2_N, output width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous clear of window state, active-high.
REQ-008 in_valid  input  1  din carries a new sample this cycle.
REQ-009 din  input  DATA_W  signed two's-complement sample.
REQ-010 out_valid  output  1  dout holds a new result this cycle.
REQ-011 dout  output  OUT_W  signed result.
REQ-012 win_full  output  1  window holds N accepted samples since the last reset or clr.

Function
REQ-013 The block SHALL store the last N accepted samples in a register-based circular buffer indexed by a LOG2_N-bit write pointer that wraps from N-1 to 0.
REQ-014 The block SHALL keep an OUT_W-bit signed running sum acc, updated on each accepted sample as acc + din - buf[wptr]; the sample then overwrites buf[wptr] and wptr increments.
REQ-015 Empty slots SHALL read as zero, so results during warm-up equal the sum of the samples accepted so far.
REQ-016 acc SHALL never overflow, because OUT_W bits hold N * (-2^(DATA_W-1)) exactly.
REQ-017 In AVG=0, dout SHALL equal the updated acc.
REQ-018 In AVG=1, dout SHALL equal (acc + 2^(LOG2_N-1)) arithmetic-shifted right by LOG2_N, sign-extended to OUT_W (round half toward +infinity).
REQ-019 Latency SHALL be one cycle: in_valid at edge k yields out_valid=1 and the new dout after edge k+1.
REQ-020 out_valid SHALL be high for exactly one cycle per accepted sample; dout SHALL hold its last value while out_valid=0.
REQ-021 Cycles with in_valid=0 SHALL leave the buffer, wptr, acc and the fill count unchanged.
REQ-022 A saturating fill counter (0..N) SHALL increment on each accepted sample; win_full SHALL be 1 when the count equals N and SHALL assert in the same cycle as the out_valid of the Nth sample.
REQ-023 When clr=1 the block SHALL zero the buffer, acc, wptr, fill count, dout, out_valid and win_full at the next edge.
REQ-024 clr and in_valid both high SHALL give clr priority; that sample is dropped, and out_valid is 0 in the following cycle.
REQ-025 Back-to-back in_valid on every cycle SHALL be accepted with no stalls at full throughput.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force buffer, acc, wptr, fill count, dout, out_valid and win_full to zero.
REQ-027 The block SHALL accept a sample presented at the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-stream SHALL discard all window contents, and no stale result SHALL appear after release.

Verification
REQ-029 Warm-up and wrap (DATA_W=16, LOG2_N=3, AVG=0): 8 samples of 100, then a sample of 0 -> dout 100, 200, ..., 800, then 700; win_full rises with the 800 result.
REQ-030 Extreme values (AVG=0): 8 samples of -32768 -> final dout -262144; then 8 samples of 32767 -> final dout 262136; no wrap at any step.
REQ-031 Average rounding (AVG=1): samples -65, -105, -83, -81, -52, 33, 68, 3 -> final sum -282, dout -35, win_full=1.
REQ-032 Gapped input: 100, gap of 3 idle cycles, 200 -> out_valid pulses exactly twice, dout 100 then 300, dout held during the idle cycles.
REQ-033 clr mid-stream: after 5 samples of 50, clr together with in_valid=1 and din=7, followed by one sample of 10 -> no out_valid in the cycle after the clr, dout 0, win_full 0, next result 10.
REQ-034 Async reset: rst_n pulsed low between clock edges mid-stream -> all outputs 0 immediately; first sample of 9 after release -> dout 9.

Source files
------------

// File: rtl/fir_mavg_param.sv
// Moving-sum / moving-average FIR over the last 2^LOG2_N accepted samples.
// A running sum is kept: each new sample adds itself and removes the one it overwrites.
module fir_mavg_param #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3,
    parameter int AVG    = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  in_valid,
    input  logic signed [DATA_W-1:0]              din,
    output logic                                  out_valid,
    output logic signed [DATA_W+LOG2_N-1:0]       dout,
    output logic                                  win_full
);

    localparam int N      = 1 << LOG2_N;
    localparam int OUT_W  = DATA_W + LOG2_N;
    localparam int FILL_W = LOG2_N + 1;

    localparam logic [FILL_W-1:0]       FILL_MAX = FILL_W'(N);
    localparam logic signed [OUT_W-1:0] HALF     = OUT_W'(1) << (LOG2_N - 1);

    logic signed [DATA_W-1:0] win_buf [N];
    logic        [LOG2_N-1:0] wptr;
    logic signed [OUT_W-1:0]  acc;
    logic        [FILL_W-1:0] fill;

    logic signed [OUT_W-1:0]  din_ext;
    logic signed [OUT_W-1:0]  old_ext;
    logic signed [OUT_W-1:0]  acc_next;
    logic signed [OUT_W-1:0]  sum_rnd;
    logic signed [OUT_W-1:0]  result;

    // Intermediate wrap in acc + din is harmless: the final value always fits in OUT_W.
    always_comb begin
        din_ext  = {{LOG2_N{din[DATA_W-1]}}, din};
        old_ext  = {{LOG2_N{win_buf[wptr][DATA_W-1]}}, win_buf[wptr]};
        acc_next = acc + din_ext - old_ext;
        sum_rnd  = acc_next + HALF;
        result   = acc_next;
        if (AVG != 0) begin
            result = sum_rnd >>> LOG2_N;
        end
    end

    // NOTE: the window memory is reset too, because empty slots must read as zero
    // so that warm-up results equal the sum of the samples seen so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                win_buf[i] <= '0;
            end
            wptr      <= '0;
            acc       <= '0;
            fill      <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                win_buf[i] <= '0;
            end
            wptr      <= '0;
            acc       <= '0;
            fill      <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                win_buf[wptr] <= din;
                wptr          <= wptr + LOG2_N'(1);
                acc           <= acc_next;
                dout          <= result;
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

    assign win_full = (fill == FILL_MAX);

endmodule

// File: tb/tb_fir_mavg_param.sv
// Self-checking bench: a sum-mode and an average-mode instance share stimulus and
// are compared each cycle against a queue-based window model.
module tb_fir_mavg_param;

    localparam int DW = 16;
    localparam int LG = 3;
    localparam int N  = 1 << LG;
    localparam int OW = DW + LG;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 out_valid0, out_valid1;
    logic signed [OW-1:0] dout0, dout1;
    logic                 win_full0, win_full1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int win[$];
    bit exp_valid = 1'b0;
    int exp_sum   = 0;
    int exp_avg   = 0;

    always #5 clk = ~clk;

    fir_mavg_param #(.DATA_W(DW), .LOG2_N(LG), .AVG(0)) dut_sum (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid0), .dout(dout0), .win_full(win_full0)
    );

    fir_mavg_param #(.DATA_W(DW), .LOG2_N(LG), .AVG(1)) dut_avg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid1), .dout(dout1), .win_full(win_full1)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int window_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    // Round half toward +infinity: floor((s + N/2) / N) with explicit floor division.
    function automatic int rounded_avg(input int s);
        int t = s + N / 2;
        int q = t / N;
        if ((t % N != 0) && (t < 0)) q--;
        return q;
    endfunction

    task automatic model_reset();
        win.delete();
        exp_valid = 1'b0;
        exp_sum   = 0;
        exp_avg   = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid_sum"}, longint'(out_valid0), longint'(exp_valid));
        check({tag, ".valid_avg"}, longint'(out_valid1), longint'(exp_valid));
        check({tag, ".dout_sum"},  longint'(dout0), longint'(exp_sum));
        check({tag, ".dout_avg"},  longint'(dout1), longint'(exp_avg));
        check({tag, ".full_sum"},  longint'(win_full0), longint'(win.size() == N));
        check({tag, ".full_avg"},  longint'(win_full1), longint'(win.size() == N));
    endtask

    // One clock cycle: drive on the falling edge, update the model at the rising
    // edge, compare 1 time unit later.
    task automatic step(input bit v, input int d, input bit c, input string tag);
        @(negedge clk);
        in_valid = v;
        din      = DW'(d);
        clr      = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > N) void'(win.pop_front());
            exp_valid = 1'b1;
            exp_sum   = window_sum();
            exp_avg   = rounded_avg(exp_sum);
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        compare_all(tag);
    endtask

    // Reset pulse strictly between clock edges; outputs must clear immediately.
    task automatic async_reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic signed [DW-1:0] r;
        int d;
        int samples[8] = '{-65, -105, -83, -81, -52, 33, 68, 3};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Warm-up and wrap
        for (int i = 0; i < N; i++) step(1'b1, 100, 1'b0, "warmup");
        check("warmup.final", longint'(dout0), 800);
        check("warmup.full", longint'(win_full0), 1);
        step(1'b1, 0, 1'b0, "wrap");
        check("wrap.final", longint'(dout0), 700);

        // Extreme values, no overflow
        step(1'b0, 0, 1'b1, "clr_a");
        for (int i = 0; i < N; i++) step(1'b1, -32768, 1'b0, "neg_ext");
        check("neg_ext.final", longint'(dout0), -262144);
        for (int i = 0; i < N; i++) step(1'b1, 32767, 1'b0, "pos_ext");
        check("pos_ext.final", longint'(dout0), 262136);

        // Average rounding
        step(1'b0, 0, 1'b1, "clr_b");
        foreach (samples[i]) step(1'b1, samples[i], 1'b0, "avg_round");
        check("avg_round.sum", longint'(dout0), -282);
        check("avg_round.avg", longint'(dout1), -35);
        check("avg_round.full", longint'(win_full1), 1);

        // Gapped input with held output
        step(1'b0, 0, 1'b1, "clr_c");
        step(1'b1, 100, 1'b0, "gap_first");
        for (int i = 0; i < 3; i++) step(1'b0, 555, 1'b0, "gap_idle");
        check("gap_idle.hold", longint'(dout0), 100);
        step(1'b1, 200, 1'b0, "gap_second");
        check("gap_second.sum", longint'(dout0), 300);

        // clr together with in_valid drops the sample
        for (int i = 0; i < 5; i++) step(1'b1, 50, 1'b0, "pre_clr");
        step(1'b1, 7, 1'b1, "clr_with_valid");
        check("clr_with_valid.valid", longint'(out_valid0), 0);
        check("clr_with_valid.dout", longint'(dout0), 0);
        step(1'b1, 10, 1'b0, "post_clr");
        check("post_clr.dout", longint'(dout0), 10);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 1000 + i, 1'b0, "pre_rst");
        async_reset_pulse("async_rst");
        step(1'b1, 9, 1'b0, "post_rst");
        check("post_rst.dout", longint'(dout0), 9);

        // Randomized traffic, including extremes, clears and reset pulses
        for (int k = 0; k < 400; k++) begin
            r = DW'($urandom);
            d = int'(r);
            case ($urandom_range(0, 9))
                0: d = -32768;
                1: d = 32767;
                default: ;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                async_reset_pulse("rand_rst");
            end
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
